store_queue: RTL and testbench
==============================

# store_queue

Parameterised store queue between the MEM stage and data BRAM port B of the R500 core. Accepts committed stores (SB/SH/SW), aligns data into byte lanes, substitutes a performance-counter snapshot when the store targets the counter window, and buffers up to DEPTH stores so the pipeline does not stall on port-B contention. Drains one store per granted cycle and flags loads that hit a pending store word.

## Interface

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- NUM_CNT, 5, number of 32-bit performance counters mapped into the counter window
- CNT_BASE, 32'h4F00, byte address of counter 0; counter k at CNT_BASE+4k

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  queue can accept; = (count < DEPTH)
- st_addr  in  32  store byte address
- st_data  in  32  rs2 value
- st_funct3  in  3  000 SB, 001 SH, 010 SW
- st_err  out  1  combinational; st_valid with misaligned or illegal funct3
- cnt_vec  in  32*NUM_CNT  counter k in bits [32k+31:32k]
- mem_gnt  in  1  port B available this cycle
- mem_req  out  1  queue non-empty
- addrb  out  32  head word address (byte address, [1:0]=0)
- web  out  4  head byte enables, gated by mem_gnt
- dib  out  32  head lane-aligned data
- ld_addr  in  32  load byte address from MEM stage
- ld_hazard  out  1  resident entry has same word address as ld_addr
- empty  out  1  count == 0 (fence/drain condition)

## Operation

- Handshake: store accepted at rising edge when st_valid && st_ready. st_ready ignores same-cycle drain (full queue never accepts, even while draining).
- Offset o = st_addr[1:0]. Legal: SB any o; SH o∈{0,2}; SW o=0. Other offsets or funct3 ∉ {000,001,010} → st_err=1; handshake still completes (if st_ready) but nothing enqueued, count unchanged.
- Source data: if st_addr == CNT_BASE+4k for k<NUM_CNT, use cnt_vec counter k sampled at the accepting edge; otherwise st_data.
- Entry fields: word address {st_addr[31:2],2'b00}; be = SB 4'b0001<<o, SH 4'b0011<<o, SW 4'b1111; data = source[7:0] placed at byte o (SB), source[15:0] at bytes o..o+1 (SH), full word (SW); unused lanes 0.
- Drain: mem_req = !empty. Head entry drives addrb/dib continuously. web = head be when mem_gnt && !empty, else 0. Head popped at edge where mem_gnt && !empty.
- FIFO order strict; no merging or coalescing. Pointers wrap mod DEPTH.
- ld_hazard: OR over resident valid entries of (entry addr[31:2] == ld_addr[31:2]); entry being accepted the same cycle not included; entry popped this cycle still included.
- Simultaneous push and pop: both take effect, count unchanged.

## Timing

- Reset (async assert, sync deassert at clk): count=0, pointers=0, entry valids cleared; mem_req=0, web=0, addrb=0, dib=0, ld_hazard=0, empty=1, st_ready=1, st_err follows inputs.
- Reset asserted mid-operation discards all pending stores; no partial write (web=0 while rst_n=0).
- Latency: store accepted at edge N is at the head and visible on port B in cycle N+1 when the queue was empty; written at edge N+1 if mem_gnt=1.
- Throughput: one push and one pop per cycle.
- Outputs addrb/dib/web/mem_req/empty/ld_hazard are functions of registered state (plus mem_gnt for web, ld_addr for ld_hazard); st_ready registered-state only.

## Test plan

- Reset then SW addr 0x100 data 0xDEADBEEF, mem_gnt=1 → next cycle addrb=0x100, web=1111, dib=0xDEADBEEF; following cycle empty=1.
- SB addr 0x203 data 0x000000AB → web=1000, dib=0xAB000000; SH addr 0x202 data 0x1234 → web=1100, dib=0x12340000.
- SW to 0x4F08 with counter 2=0x55 at accept, counter later changed to 0x99 before drain → dib=0x55; SW to 0x4F14 (NUM_CNT=5) → dib=st_data.
- mem_gnt=0, push DEPTH stores → st_ready=0, 5th st_valid not accepted; raise mem_gnt with concurrent st_valid → one pop/cycle, order preserved, push resumes only after count<DEPTH.
- SH at 0x101, SW at 0x102, funct3=011 → st_err=1 each, count unchanged, no web activity.
- Pending SB 0x300 with mem_gnt=0, ld_addr=0x302 → ld_hazard=1; ld_addr=0x304 → 0; assert rst_n=0 mid-queue → empty=1, web=0, no write after release.

Source files
------------

// File: rtl/store_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_queue                                                          |
// | Lane-aligning store FIFO between MEM stage and data BRAM port B.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module store_queue #(
  parameter int          DEPTH    = 4,
  parameter int          NUM_CNT  = 5,
  parameter logic [31:0] CNT_BASE = 32'h4F00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [31:0]           st_addr,
  input  logic [31:0]           st_data,
  input  logic [2:0]            st_funct3,
  output logic                  st_err,
  input  logic [32*NUM_CNT-1:0] cnt_vec,
  input  logic                  mem_gnt,
  output logic                  mem_req,
  output logic [31:0]           addrb,
  output logic [3:0]            web,
  output logic [31:0]           dib,
  input  logic [31:0]           ld_addr,
  output logic                  ld_hazard,
  output logic                  empty
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

  logic [29:0]        r_waddr [DEPTH];
  logic [3:0]         r_be    [DEPTH];
  logic [31:0]        r_data  [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;

  logic [1:0]         w_off;
  logic [NUM_CNT-1:0] w_cnt_hit;
  logic [31:0]        w_src;
  logic               w_legal;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [DEPTH-1:0]   w_hit;
  logic               w_push;
  logic               w_pop;

  assign w_off = st_addr[1:0];

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    assign w_cnt_hit[k] = (st_addr == CNT_BASE + 32'(4 * k));
  end

  // Counter window address swaps the rs2 value for that counter's snapshot.
  always_comb begin
    w_src = st_data;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (w_cnt_hit[k]) w_src = cnt_vec[32*k +: 32];
    end
  end

  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    case (st_funct3)
      3'b000: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << w_off;
        w_wdata = {24'h0, w_src[7:0]} << {w_off, 3'b000};
      end
      3'b001: begin
        w_legal = !w_off[0];
        w_be    = 4'b0011 << w_off;
        w_wdata = {16'h0, w_src[15:0]} << {w_off, 3'b000};
      end
      3'b010: begin
        w_legal = (w_off == 2'b00);
        w_be    = 4'b1111;
        w_wdata = w_src;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign empty    = (r_count == '0);
  assign st_ready = (r_count < c_FULL);
  assign st_err   = st_valid && !w_legal;
  assign mem_req  = !empty;
  assign w_push   = st_valid && st_ready && w_legal;
  assign w_pop    = mem_gnt && !empty;

  assign addrb = empty ? 32'h0 : {r_waddr[r_rptr], 2'b00};
  assign dib   = empty ? 32'h0 : r_data[r_rptr];
  assign web   = w_pop ? r_be[r_rptr] : 4'b0000;

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign w_hit[i] = r_valid[i] && (r_waddr[i] == ld_addr[31:2]);
  end
  assign ld_hazard = |w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_waddr[i] <= '0;
        r_be[i]    <= '0;
        r_data[i]  <= '0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_valid[r_wptr] <= 1'b1;
        r_waddr[r_wptr] <= st_addr[31:2];
        r_be[r_wptr]    <= w_be;
        r_data[r_wptr]  <= w_wdata;
        r_wptr          <= r_wptr + 1'b1;
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_store_queue                                                       |
// | Directed vector table plus multi-cycle sequences for store_queue.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_store_queue;

  localparam int c_NUM_CNT = 5;
  localparam int c_NV      = 13;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    st_valid = 1'b0;
  logic                    st_ready;
  logic [31:0]             st_addr = '0;
  logic [31:0]             st_data = '0;
  logic [2:0]              st_funct3 = '0;
  logic                    st_err;
  logic [32*c_NUM_CNT-1:0] cnt_vec = '0;
  logic                    mem_gnt = 1'b0;
  logic                    mem_req;
  logic [31:0]             addrb;
  logic [3:0]              web;
  logic [31:0]             dib;
  logic [31:0]             ld_addr = '0;
  logic                    ld_hazard;
  logic                    empty;

  int n_chk  = 0;
  int n_fail = 0;

  store_queue #(.DEPTH(4), .NUM_CNT(c_NUM_CNT), .CNT_BASE(32'h4F00)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .st_err(st_err), .cnt_vec(cnt_vec), .mem_gnt(mem_gnt),
    .mem_req(mem_req), .addrb(addrb), .web(web), .dib(dib),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic        err;
    logic [31:0] exp_addr;
    logic [3:0]  be;
    logic [31:0] exp_dib;
  } vec_t;

  vec_t vt [c_NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f;
  endtask

  logic [31:0] exp_head [5];
  logic        exp_rdy  [5];

  initial begin
    for (int k = 0; k < c_NUM_CNT; k++) cnt_vec[32*k +: 32] = 32'h1000_0000 + k;

    vt[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF};
    vt[1]  = '{32'h0000_0203, 32'h0000_00AB, 3'b000, 1'b0, 32'h0000_0200, 4'b1000, 32'hAB00_0000};
    vt[2]  = '{32'h0000_0202, 32'h0000_1234, 3'b001, 1'b0, 32'h0000_0200, 4'b1100, 32'h1234_0000};
    vt[3]  = '{32'h0000_0201, 32'h1122_3344, 3'b000, 1'b0, 32'h0000_0200, 4'b0010, 32'h0000_4400};
    vt[4]  = '{32'h0000_0100, 32'hAABB_CCDD, 3'b001, 1'b0, 32'h0000_0100, 4'b0011, 32'h0000_CCDD};
    vt[5]  = '{32'h0000_4F14, 32'hCAFE_F00D, 3'b010, 1'b0, 32'h0000_4F14, 4'b1111, 32'hCAFE_F00D};
    vt[6]  = '{32'h0000_4F00, 32'h0000_0001, 3'b010, 1'b0, 32'h0000_4F00, 4'b1111, 32'h1000_0000};
    vt[7]  = '{32'h0000_4F04, 32'h0000_0077, 3'b000, 1'b0, 32'h0000_4F04, 4'b0001, 32'h0000_0001};
    vt[8]  = '{32'h0000_4F10, 32'h0000_0000, 3'b010, 1'b0, 32'h0000_4F10, 4'b1111, 32'h1000_0004};
    vt[9]  = '{32'h0000_0101, 32'h0000_5555, 3'b001, 1'b1, 32'h0, 4'b0000, 32'h0};
    vt[10] = '{32'h0000_0102, 32'h0000_5555, 3'b010, 1'b1, 32'h0, 4'b0000, 32'h0};
    vt[11] = '{32'h0000_0100, 32'h0000_5555, 3'b011, 1'b1, 32'h0, 4'b0000, 32'h0};
    vt[12] = '{32'h0000_0100, 32'h0000_5555, 3'b100, 1'b1, 32'h0, 4'b0000, 32'h0};

    // Reset state
    #12;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_web", 32'(web), 32'd0);
    chk("rst_addrb", addrb, 32'd0);
    chk("rst_dib", dib, 32'd0);
    chk("rst_ld_hazard", 32'(ld_hazard), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-store vectors, drained with mem_gnt=1
    for (int v = 0; v < c_NV; v++) begin
      @(negedge clk);
      mem_gnt = 1'b1;
      drive_st(vt[v].addr, vt[v].data, vt[v].f3);
      #1 chk($sformatf("v%0d_st_err", v), 32'(st_err), 32'(vt[v].err));
      @(posedge clk);
      @(negedge clk);
      st_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_empty", v), 32'(empty), 32'(vt[v].err));
      if (!vt[v].err) begin
        chk($sformatf("v%0d_addrb", v), addrb, vt[v].exp_addr);
        chk($sformatf("v%0d_web", v), 32'(web), 32'(vt[v].be));
        chk($sformatf("v%0d_dib", v), dib, vt[v].exp_dib);
      end else begin
        chk($sformatf("v%0d_web_idle", v), 32'(web), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      #1 chk($sformatf("v%0d_drained", v), 32'(empty), 32'd1);
    end

    // Counter snapshot is taken at accept, not at drain
    @(negedge clk);
    mem_gnt = 1'b0;
    cnt_vec[64 +: 32] = 32'h0000_0055;
    drive_st(32'h0000_4F08, 32'h0000_0012, 3'b010);
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    cnt_vec[64 +: 32] = 32'h0000_0099;
    #1;
    chk("snap_dib", dib, 32'h0000_0055);
    chk("snap_web_nogrant", 32'(web), 32'd0);
    mem_gnt = 1'b1;
    #1 chk("snap_web_grant", 32'(web), 32'hF);
    @(posedge clk);
    @(negedge clk);
    #1 chk("snap_drained", 32'(empty), 32'd1);

    // Fill, blocked fifth store, then drain with concurrent push
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_st(32'h10 * (i + 1), i + 1, 3'b010);
      @(posedge clk);
      @(negedge clk);
    end
    drive_st(32'h0000_0500, 32'h0000_0055, 3'b010);
    #1 chk("full_st_ready", 32'(st_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("full_head_kept", dib, 32'd1);
    chk("full_still_blocked", 32'(st_ready), 32'd0);
    exp_head = '{32'd1, 32'd2, 32'd3, 32'd4, 32'h55};
    exp_rdy  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      st_valid = (i < 2);
      mem_gnt  = 1'b1;
      #1;
      chk($sformatf("drain%0d_dib", i), dib, exp_head[i]);
      chk($sformatf("drain%0d_st_ready", i), 32'(st_ready), 32'(exp_rdy[i]));
      @(posedge clk);
      @(negedge clk);
    end
    st_valid = 1'b0;
    #1 chk("drain_empty", 32'(empty), 32'd1);

    // Load hazard detection and mid-queue reset
    mem_gnt = 1'b0;
    drive_st(32'h0000_0300, 32'h0000_00EE, 3'b000);
    ld_addr = 32'h0000_0300;
    #1 chk("haz_same_cycle", 32'(ld_hazard), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive_st(32'h0000_0400, 32'h0000_0011, 3'b010);
    ld_addr = 32'h0000_0302;
    #1 chk("haz_hit", 32'(ld_hazard), 32'd1);
    ld_addr = 32'h0000_0304;
    #1 chk("haz_miss", 32'(ld_hazard), 32'd0);
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    mem_gnt  = 1'b1;
    ld_addr  = 32'h0000_0300;
    #1 chk("haz_popping", 32'(ld_hazard), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_web", 32'(web), 32'd0);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_hazard", 32'(ld_hazard), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("postrst_empty", 32'(empty), 32'd1);
    chk("postrst_web", 32'(web), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
